// File: rtl/ysyx_exu_sched_pkg.sv
// Shared types for the EXU issue scheduler.
//  YSYX_RS_SIZE   : default reservation-station depth
//  sched_mul_st_t : multiplier tracking FSM states
//  sched_ld_st_t  : load-port tracking FSM states
package ysyx_exu_sched_pkg;

    localparam int unsigned YSYX_RS_SIZE = 4;

    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_BUSY  = 2'd1,
        MUL_DRAIN = 2'd2
    } sched_mul_st_t;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_REQ   = 2'd1,
        LD_WAIT  = 2'd2,
        LD_DRAIN = 2'd3
    } sched_ld_st_t;

endpackage

// File: rtl/ysyx_exu_age_matrix.sv
// Age matrix over the RS entries plus oldest-first selection.
// One state copy serves both the mul and the ld request vectors.
//  clock/reset              : clock, async active-low reset
//  flush                    : clears valid bits and ages, suppresses grants
//  alloc_valid/alloc_idx    : entry allocated (becomes youngest)
//  rel_valid/rel_idx        : entry freed
//  req_a/req_b              : raw request vectors
//  gnt_a/gnt_b, found_a/b   : one-hot oldest eligible requester and found flag
module ysyx_exu_age_matrix
    import ysyx_exu_sched_pkg::*;
#(
    parameter int unsigned RS_SIZE = YSYX_RS_SIZE,
    localparam int unsigned IW = $clog2(RS_SIZE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               alloc_valid,
    input  logic [IW-1:0]      alloc_idx,
    input  logic               rel_valid,
    input  logic [IW-1:0]      rel_idx,
    input  logic [RS_SIZE-1:0] req_a,
    input  logic [RS_SIZE-1:0] req_b,
    output logic [RS_SIZE-1:0] gnt_a,
    output logic [RS_SIZE-1:0] gnt_b,
    output logic               found_a,
    output logic               found_b
);

    // older_q[i][j] = entry i was allocated before entry j
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;
    logic [RS_SIZE-1:0]              valid_q, valid_d;
    logic [RS_SIZE-1:0]              rel_mask, eff_a, eff_b;
    logic                            blk_a, blk_b;

    // Allocation makes the entry younger than every currently valid entry
    always_comb begin
        valid_d = valid_q;
        older_d = older_q;
        if (flush) begin
            valid_d = '0;
            older_d = '0;
        end else begin
            if (rel_valid) valid_d[rel_idx] = 1'b0;
            if (alloc_valid) begin
                valid_d[alloc_idx] = 1'b1;
                older_d[alloc_idx] = '0;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (IW'(i) != alloc_idx) older_d[i][alloc_idx] = valid_q[i];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            older_q <= '0;
        end else begin
            valid_q <= valid_d;
            older_q <= older_d;
        end
    end

    // An entry being freed this cycle is no longer eligible; no grants during flush
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            rel_mask[i] = rel_valid && (rel_idx == IW'(i));
        end
        eff_a = flush ? '0 : (req_a & valid_q & ~rel_mask);
        eff_b = flush ? '0 : (req_b & valid_q & ~rel_mask);
    end

    // Grant i when no older entry is also requesting
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        blk_a = 1'b0;
        blk_b = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            blk_a = 1'b0;
            blk_b = 1'b0;
            for (int j = 0; j < RS_SIZE; j++) begin
                blk_a = blk_a | (eff_a[j] & older_q[j][i]);
                blk_b = blk_b | (eff_b[j] & older_q[j][i]);
            end
            gnt_a[i] = eff_a[i] & ~blk_a;
            gnt_b[i] = eff_b[i] & ~blk_b;
        end
        found_a = |gnt_a;
        found_b = |gnt_b;
    end

endmodule

// File: rtl/ysyx_exu_sched.sv
// Oldest-first issue scheduler for the multiplier and the single LSU load port.
//  clock/reset, flush                  : clock, async active-low reset, pipeline flush
//  alloc_*/rel_*                       : RS entry allocate / free
//  mul_req/ld_req                      : per-entry ready requests
//  mul_in_valid/mul_idx/mul_done       : multiplier issue and completion to RS
//  mul_out_valid                       : multiplier result valid
//  ld_valid/ld_idx/ld_done             : load request and completion to RS
//  ld_ready/ld_rvalid                  : LSU accept / read data valid
module ysyx_exu_sched
    import ysyx_exu_sched_pkg::*;
#(
    parameter int unsigned RS_SIZE = YSYX_RS_SIZE,
    localparam int unsigned IW = $clog2(RS_SIZE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               alloc_valid,
    input  logic [IW-1:0]      alloc_idx,
    input  logic               rel_valid,
    input  logic [IW-1:0]      rel_idx,
    input  logic [RS_SIZE-1:0] mul_req,
    input  logic [RS_SIZE-1:0] ld_req,
    output logic               mul_in_valid,
    output logic [IW-1:0]      mul_idx,
    input  logic               mul_out_valid,
    output logic               mul_done,
    output logic               ld_valid,
    output logic [IW-1:0]      ld_idx,
    input  logic               ld_ready,
    input  logic               ld_rvalid,
    output logic               ld_done
);

    sched_mul_st_t      mul_st_q, mul_st_d;
    sched_ld_st_t       ld_st_q, ld_st_d;
    logic [IW-1:0]      mul_idx_q, mul_idx_d, ld_idx_q, ld_idx_d;
    logic               mul_in_valid_q, mul_in_valid_d, ld_valid_q, ld_valid_d;
    logic               mul_done_c, ld_done_c, mul_kill, ld_kill;
    logic [RS_SIZE-1:0] mul_gnt, ld_gnt;
    logic               mul_found, ld_found;
    logic [IW-1:0]      mul_gnt_idx, ld_gnt_idx;

    ysyx_exu_age_matrix #(.RS_SIZE(RS_SIZE)) u_age (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .rel_valid   (rel_valid),
        .rel_idx     (rel_idx),
        .req_a       (mul_req),
        .req_b       (ld_req),
        .gnt_a       (mul_gnt),
        .gnt_b       (ld_gnt),
        .found_a     (mul_found),
        .found_b     (ld_found)
    );

    // One-hot grant to index
    always_comb begin
        mul_gnt_idx = '0;
        ld_gnt_idx  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (mul_gnt[i]) mul_gnt_idx = IW'(i);
            if (ld_gnt[i])  ld_gnt_idx  = IW'(i);
        end
    end

    // A flush or a free of the in-flight entry turns its result into a discard
    always_comb begin
        mul_kill = flush || (rel_valid && (rel_idx == mul_idx_q));
        ld_kill  = flush || (rel_valid && (rel_idx == ld_idx_q));
    end

    // Multiplier tracking
    always_comb begin
        mul_st_d       = mul_st_q;
        mul_idx_d      = mul_idx_q;
        mul_in_valid_d = 1'b0;
        mul_done_c     = 1'b0;
        case (mul_st_q)
            MUL_IDLE: begin
                if (mul_found) begin
                    mul_st_d       = MUL_BUSY;
                    mul_idx_d      = mul_gnt_idx;
                    mul_in_valid_d = 1'b1;
                end
            end
            MUL_BUSY: begin
                if (mul_out_valid) begin
                    mul_st_d   = MUL_IDLE;
                    mul_done_c = !mul_kill;
                end else if (mul_kill) begin
                    mul_st_d = MUL_DRAIN;
                end
            end
            MUL_DRAIN: begin
                if (mul_out_valid) mul_st_d = MUL_IDLE;
            end
            default: mul_st_d = MUL_IDLE;
        endcase
    end

    // Load port tracking
    always_comb begin
        ld_st_d   = ld_st_q;
        ld_idx_d  = ld_idx_q;
        ld_done_c = 1'b0;
        case (ld_st_q)
            LD_IDLE: begin
                if (ld_found) begin
                    ld_st_d  = LD_REQ;
                    ld_idx_d = ld_gnt_idx;
                end
            end
            LD_REQ: begin
                if (ld_ready) begin
                    if (ld_rvalid) begin
                        ld_st_d   = LD_IDLE;
                        ld_done_c = !flush;
                    end else begin
                        ld_st_d = flush ? LD_DRAIN : LD_WAIT;
                    end
                end else if (flush) begin
                    ld_st_d = LD_IDLE;
                end
            end
            LD_WAIT: begin
                if (ld_rvalid) begin
                    ld_st_d   = LD_IDLE;
                    ld_done_c = !ld_kill;
                end else if (ld_kill) begin
                    ld_st_d = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                if (ld_rvalid) ld_st_d = LD_IDLE;
            end
            default: ld_st_d = LD_IDLE;
        endcase
        ld_valid_d = (ld_st_d == LD_REQ);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mul_st_q       <= MUL_IDLE;
            ld_st_q        <= LD_IDLE;
            mul_idx_q      <= '0;
            ld_idx_q       <= '0;
            mul_in_valid_q <= 1'b0;
            ld_valid_q     <= 1'b0;
        end else begin
            mul_st_q       <= mul_st_d;
            ld_st_q        <= ld_st_d;
            mul_idx_q      <= mul_idx_d;
            ld_idx_q       <= ld_idx_d;
            mul_in_valid_q <= mul_in_valid_d;
            ld_valid_q     <= ld_valid_d;
        end
    end

    // Freeing an entry while its operation is outstanding is an RS bug
    always @(posedge clock) begin
        if (reset && rel_valid) begin
            assert (!(mul_st_q == MUL_BUSY && rel_idx == mul_idx_q));
            assert (!(ld_st_q == LD_WAIT && rel_idx == ld_idx_q));
        end
    end

    assign mul_in_valid = mul_in_valid_q;
    assign mul_idx      = mul_idx_q;
    assign mul_done     = mul_done_c;
    assign ld_valid     = ld_valid_q;
    assign ld_idx       = ld_idx_q;
    assign ld_done      = ld_done_c;

endmodule

// File: tb/tb_ysyx_exu_sched.sv
// Bench for ysyx_exu_sched: directed scenarios, then random traffic, all checked
// against a queue-based age model and per-resource in-flight flags.
module tb_ysyx_exu_sched;

    localparam int unsigned RS = 4;
    localparam int unsigned IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush, alloc_valid, rel_valid;
    logic [IW-1:0] alloc_idx, rel_idx;
    logic [RS-1:0] mul_req, ld_req;
    logic          mul_in_valid, mul_out_valid, mul_done;
    logic [IW-1:0] mul_idx, ld_idx;
    logic          ld_valid, ld_ready, ld_rvalid, ld_done;

    always #5 clock = ~clock;

    ysyx_exu_sched #(.RS_SIZE(RS)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_idx     (alloc_idx),
        .rel_valid     (rel_valid),
        .rel_idx       (rel_idx),
        .mul_req       (mul_req),
        .ld_req        (ld_req),
        .mul_in_valid  (mul_in_valid),
        .mul_idx       (mul_idx),
        .mul_out_valid (mul_out_valid),
        .mul_done      (mul_done),
        .ld_valid      (ld_valid),
        .ld_idx        (ld_idx),
        .ld_ready      (ld_ready),
        .ld_rvalid     (ld_rvalid),
        .ld_done       (ld_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: allocation-ordered list of live entries (front = oldest)
    int age_list[$];
    bit m_mul_start, m_mul_busy, m_mul_disc;
    int m_mul_idx;
    bit m_ld_pend, m_ld_wait, m_ld_disc;
    int m_ld_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        age_list.delete();
        m_mul_start = 0; m_mul_busy = 0; m_mul_disc = 0; m_mul_idx = 0;
        m_ld_pend = 0; m_ld_wait = 0; m_ld_disc = 0; m_ld_idx = 0;
    endfunction

    function automatic void m_remove(input int k);
        for (int p = age_list.size() - 1; p >= 0; p--) begin
            if (age_list[p] == k) age_list.delete(p);
        end
    endfunction

    function automatic bit m_live(input int k);
        foreach (age_list[p]) if (age_list[p] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_oldest(input logic [RS-1:0] req);
        if (flush) return -1;
        foreach (age_list[p]) begin
            if (req[age_list[p]] && !(rel_valid && int'(rel_idx) == age_list[p])) return age_list[p];
        end
        return -1;
    endfunction

    task automatic set_idle();
        flush = 0; alloc_valid = 0; alloc_idx = '0; rel_valid = 0; rel_idx = '0;
        mul_req = '0; ld_req = '0; mul_out_valid = 0; ld_ready = 0; ld_rvalid = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mul_in_valid"}, 32'(mul_in_valid), 32'd0);
        chk({tag, "_mul_idx"},      32'(mul_idx),      32'd0);
        chk({tag, "_mul_done"},     32'(mul_done),     32'd0);
        chk({tag, "_ld_valid"},     32'(ld_valid),     32'd0);
        chk({tag, "_ld_idx"},       32'(ld_idx),       32'd0);
        chk({tag, "_ld_done"},      32'(ld_done),      32'd0);
    endtask

    // Check this cycle's outputs against the model, advance the model, move to next negedge
    task automatic step();
        bit kill_m, kill_l;
        int g;
        #1;
        kill_m = flush || (rel_valid && int'(rel_idx) == m_mul_idx);
        kill_l = flush || (rel_valid && int'(rel_idx) == m_ld_idx);
        chk("mul_in_valid", 32'(mul_in_valid), 32'(m_mul_start));
        chk("mul_idx",      32'(mul_idx),      32'(m_mul_idx));
        chk("mul_done",     32'(mul_done),     32'(m_mul_busy && mul_out_valid && !kill_m));
        chk("ld_valid",     32'(ld_valid),     32'(m_ld_pend));
        chk("ld_idx",       32'(ld_idx),       32'(m_ld_idx));
        chk("ld_done",      32'(ld_done),
            32'((m_ld_pend && ld_ready && ld_rvalid && !flush) || (m_ld_wait && ld_rvalid && !kill_l)));

        m_mul_start = 0;
        if (m_mul_busy) begin
            if (mul_out_valid) m_mul_busy = 0;
            else if (kill_m) begin m_mul_busy = 0; m_mul_disc = 1; end
        end else if (m_mul_disc) begin
            if (mul_out_valid) m_mul_disc = 0;
        end else begin
            g = m_oldest(mul_req);
            if (g >= 0) begin m_mul_busy = 1; m_mul_start = 1; m_mul_idx = g; end
        end

        if (m_ld_pend) begin
            if (ld_ready) begin
                m_ld_pend = 0;
                if (!ld_rvalid) begin
                    if (flush) m_ld_disc = 1;
                    else m_ld_wait = 1;
                end
            end else if (flush) m_ld_pend = 0;
        end else if (m_ld_wait) begin
            if (ld_rvalid) m_ld_wait = 0;
            else if (kill_l) begin m_ld_wait = 0; m_ld_disc = 1; end
        end else if (m_ld_disc) begin
            if (ld_rvalid) m_ld_disc = 0;
        end else begin
            g = m_oldest(ld_req);
            if (g >= 0) begin m_ld_pend = 1; m_ld_idx = g; end
        end

        if (flush) age_list.delete();
        else begin
            if (rel_valid) m_remove(int'(rel_idx));
            if (alloc_valid) begin
                m_remove(int'(alloc_idx));
                age_list.push_back(int'(alloc_idx));
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int k;
        reset = 1'b0;
        set_idle();
        m_reset();
        repeat (2) @(negedge clock);
        #1 chk_zero("rst");
        @(negedge clock);
        reset = 1'b1;

        // Scenario 1: age order 2,0,3; oldest mul requester first
        alloc_valid = 1; alloc_idx = 2; step();
        alloc_idx = 0; step();
        alloc_idx = 3; step();
        alloc_valid = 0;
        mul_req = 4'b1101; step();
        #1 chk("t1_issue", 32'(mul_in_valid), 32'd1);
        chk("t1_idx", 32'(mul_idx), 32'd2);
        step();
        repeat (4) step();
        mul_out_valid = 1;
        #1 chk("t1_done", 32'(mul_done), 32'd1);
        step();
        mul_out_valid = 0; mul_req = 4'b1001; step();
        #1 chk("t1_next_issue", 32'(mul_in_valid), 32'd1);
        chk("t1_next_idx", 32'(mul_idx), 32'd0);
        step();
        repeat (2) step();
        mul_out_valid = 1; step();
        mul_out_valid = 0; mul_req = '0; step();

        // Scenario 2: re-allocated entry is youngest; same-cycle rel+alloc
        rel_valid = 1; rel_idx = 2; step();
        rel_valid = 0; alloc_valid = 1; alloc_idx = 2; step();
        alloc_valid = 0; ld_req = 4'b0101; step();
        ld_ready = 1; ld_rvalid = 1;
        #1 chk("t2_ld_idx0", 32'(ld_idx), 32'd0);
        chk("t2_done0", 32'(ld_done), 32'd1);
        step();
        ld_ready = 0; ld_rvalid = 0; ld_req = 4'b0100; step();
        ld_ready = 1;
        #1 chk("t2_ld_idx2", 32'(ld_idx), 32'd2);
        step();
        ld_ready = 0; ld_rvalid = 1;
        #1 chk("t2_done2", 32'(ld_done), 32'd1);
        step();
        ld_rvalid = 0; ld_req = '0;
        alloc_valid = 1; alloc_idx = 1; step();
        rel_valid = 1; rel_idx = 3; alloc_idx = 3; step();
        rel_idx = 1; alloc_idx = 1; step();
        rel_valid = 0; alloc_valid = 0; ld_req = 4'b1010; step();
        #1 chk("t2_youngest", 32'(ld_idx), 32'd3);
        ld_ready = 1; ld_rvalid = 1; step();
        ld_ready = 0; ld_rvalid = 0; ld_req = '0; step();

        // Scenario 3: ld_valid/ld_idx hold while LSU stalls
        ld_req = 4'b0010; step();
        repeat (3) begin
            #1 chk("t3_hold_valid", 32'(ld_valid), 32'd1);
            chk("t3_hold_idx", 32'(ld_idx), 32'd1);
            step();
        end
        ld_ready = 1; ld_rvalid = 1;
        #1 chk("t3_done", 32'(ld_done), 32'd1);
        step();
        ld_ready = 0; ld_rvalid = 0; ld_req = '0; step();

        // Scenario 4: flush while multiplier busy discards its result
        mul_req = 4'b0001; step();
        mul_req = '0; step();
        flush = 1; step();
        flush = 0; step();
        mul_out_valid = 1;
        #1 chk("t4_no_done", 32'(mul_done), 32'd0);
        step();
        mul_out_valid = 0; mul_req = 4'b1111; ld_req = 4'b1111; step();
        #1 chk("t4_no_mul_grant", 32'(mul_in_valid), 32'd0);
        chk("t4_no_ld_grant", 32'(ld_valid), 32'd0);
        step();
        step();
        mul_req = '0; ld_req = '0;

        // Scenario 5: both resources granted to the same entry in one cycle
        alloc_valid = 1; alloc_idx = 0; step();
        alloc_idx = 1; step();
        alloc_valid = 0; mul_req = 4'b0010; ld_req = 4'b0010; step();
        #1 chk("t5_mul_issue", 32'(mul_in_valid), 32'd1);
        chk("t5_mul_idx", 32'(mul_idx), 32'd1);
        chk("t5_ld_valid", 32'(ld_valid), 32'd1);
        chk("t5_ld_idx", 32'(ld_idx), 32'd1);
        ld_ready = 1; step();
        ld_ready = 0; step();
        mul_out_valid = 1;
        #1 chk("t5_mul_done", 32'(mul_done), 32'd1);
        chk("t5_ld_not_done", 32'(ld_done), 32'd0);
        step();
        mul_out_valid = 0; mul_req = '0; ld_rvalid = 1;
        #1 chk("t5_ld_done", 32'(ld_done), 32'd1);
        step();
        ld_rvalid = 0; ld_req = '0; step();

        // Scenario 6: asynchronous reset while a load waits for data
        ld_req = 4'b0001; step();
        ld_req = '0; ld_ready = 1; step();
        ld_ready = 0; step();
        #2 reset = 1'b0;
        #1 chk_zero("t6_async");
        m_reset();
        @(negedge clock);
        reset = 1'b1; ld_rvalid = 1;
        #1 chk("t6_dropped", 32'(ld_done), 32'd0);
        step();
        ld_rvalid = 0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            set_idle();
            flush = ($urandom_range(0, 31) == 0);
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_idx = IW'($urandom_range(0, RS - 1));
            k = int'($urandom_range(0, RS - 1));
            rel_valid = ($urandom_range(0, 3) == 0) && m_live(k)
                        && !(m_mul_busy && k == m_mul_idx)
                        && !((m_ld_pend || m_ld_wait) && k == m_ld_idx);
            rel_idx = IW'(k);
            mul_req = RS'($urandom);
            ld_req = RS'($urandom);
            mul_out_valid = ((m_mul_busy && !m_mul_start) || m_mul_disc) && ($urandom_range(0, 3) == 0);
            ld_ready = m_ld_pend && ($urandom_range(0, 2) == 0);
            ld_rvalid = ((m_ld_pend && ld_ready) || m_ld_wait || m_ld_disc) && ($urandom_range(0, 2) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
